pd_packet_serializer: RTL and testbench
=======================================

Name: pd_packet_serializer

Overview:
Parametrised successor of the hash-separation stage in the result packet path. It captures a sync/PID header, a status flag and PAYLOAD_WORDS of hash/nonce data, then streams them one word per accepted beat over a valid/ready interface to the transmit FIFO/USB side. It adds a packet FSM, backpressure, explicit start/done/abort and an optional CRC trailer.

Parameters:
WORD_W, 16, output word width; legal values are 16 or greater.
PAYLOAD_WORDS, 18, number of payload words per packet; legal values are 1 or greater.
SYNC_BYTE, 8'h80, sync pattern placed in the header word.

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request to capture inputs and send a packet
abort  in  1  drop the current packet
pid  in  8  packet ID, captured on accepted start
status_empty  in  1  status flag, captured on accepted start
payload_in  in  PAYLOAD_WORDS*WORD_W  payload; word 0 = most significant WORD_W bits
tx_ready  in  1  sink accepts the word this cycle
tx_valid  out  1  tx_data is valid
tx_data  out  WORD_W  current word
tx_last  out  1  marks the final word of the packet
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset: clk is the clock; n_rst is an asynchronous, active-low reset.
  - All outputs reset to 0.
  - FSM resets to IDLE.
  - Capture registers and word counter reset to 0.
- Beat: a beat completes on a clock edge where tx_valid and tx_ready are both high.
- FSM states: IDLE, HDR, STAT, PAY, (CRC), DONE.
- IDLE:
  - start=1 and abort=0 → register pid, status_empty and payload_in; counter=0; go to HDR.
  - tx_valid rises in the cycle after start (latency 1).
- HDR:
  - tx_data = {zeros, SYNC_BYTE, pid_reg}, zero-extended to WORD_W.
  - On a beat → STAT.
- STAT:
  - tx_data = status_empty_reg, zero-extended (0 or 1).
  - On a beat → PAY.
- PAY:
  - tx_data = payload word [counter]; word k = payload_in bits [(PAYLOAD_WORDS-k)*WORD_W-1 -: WORD_W].
  - Counter increments on each beat.
  - On the beat with counter = PAYLOAD_WORDS-1 → DONE, or → CRC if PD_CRC16_EN is defined.
- DONE:
  - tx_valid=0, done=1 for exactly one cycle, then → IDLE.
  - busy is still 1 in DONE.
- tx_valid is 1 only in HDR, STAT, PAY and CRC.
- While tx_valid=1 and tx_ready=0, tx_data and tx_last hold stable. tx_valid never drops without a beat, except on abort.
- tx_data = 0 whenever tx_valid=0.
- tx_last = 1 on the final word only:
  - the last PAY word without CRC;
  - the CRC word with CRC.
- Captured values are immune to input changes during a packet. start while busy=1 is ignored (not queued).
- abort = 1 in any non-IDLE state:
  - Next state is IDLE; tx_valid drops on the next edge; no done pulse.
  - The in-flight word is discarded even if a beat completes in the same cycle.
- start and abort in the same IDLE cycle: abort wins and no packet starts.
- Counter width is $clog2(PAYLOAD_WORDS+1); it never wraps within a packet.
- Packet length:
  - PAYLOAD_WORDS+2 words without CRC.
  - PAYLOAD_WORDS+3 words with CRC.

Optional Feature:
Macro: PD_CRC16_EN
- Defined:
  - Adds state CRC after PAY.
  - CRC-16/CCITT: poly 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Computed MSB-first over every word accepted in HDR, STAT and PAY (all WORD_W bits); updated on each beat.
  - CRC register re-initialised to 0xFFFF on accepted start.
  - CRC state: tx_data = CRC zero-extended, tx_last=1; on a beat → DONE.
- Undefined:
  - No CRC logic and no CRC state.
  - tx_last is asserted on the final payload word.

Test Plan:
1. Reset, then start with pid=8'h2D, status_empty=1, PAYLOAD_WORDS=18, payload words 16'h0100..16'h0111, tx_ready=1 → words 16'h802D, 16'h0001, 16'h0100..16'h0111 on 20 consecutive cycles; tx_last only on 16'h0111; done pulses once after it.
2. Same packet with tx_ready toggling 1,0,0,1,… → identical word sequence; tx_data/tx_last stable across stalled cycles; no word lost or duplicated.
3. Change payload_in and pid and assert start again mid-packet → output still carries the originally captured values; the second start is ignored; busy=1 throughout.
4. abort asserted during PAY word 5 → tx_valid=0 and busy=0 one cycle later; no done; a following start sends a full fresh packet beginning with header 16'h80xx.
5. start and abort in the same IDLE cycle → busy stays 0 and tx_valid stays 0.
6. With PD_CRC16_EN, PAYLOAD_WORDS=1, pid=8'h00, status_empty=0, payload 16'h0000 → 4 words: 16'h8000, 16'h0000, 16'h0000, then the CRC word matching the reference model; tx_last on the CRC word only.

Source files
------------

// File: rtl/pd_packet_serializer.sv
// pd_packet_serializer
// Captures a sync/PID header, a status flag and PAYLOAD_WORDS payload words on
// an accepted start, then streams them one word per beat over valid/ready.
// Packet: header {SYNC_BYTE, pid}, status word, payload words (MSB word first).
// Optional feature macro: PD_CRC16_EN appends a CRC-16/CCITT trailer word
// (poly 0x1021, init 0xFFFF, MSB-first) computed over every accepted word.
module pd_packet_serializer #(
    parameter int         WORD_W        = 16,
    parameter int         PAYLOAD_WORDS = 18,
    parameter logic [7:0] SYNC_BYTE     = 8'h80
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [7:0]                      pid,
    input  logic                            status_empty,
    input  logic [PAYLOAD_WORDS*WORD_W-1:0] payload_in,
    input  logic                            tx_ready,
    output logic                            tx_valid,
    output logic [WORD_W-1:0]               tx_data,
    output logic                            tx_last,
    output logic                            busy,
    output logic                            done
);

    localparam int PAY_W = PAYLOAD_WORDS * WORD_W;
    localparam int CNT_W = $clog2(PAYLOAD_WORDS + 1);
    localparam int IDX_W = $clog2(PAY_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_WORDS - 1);

`ifdef PD_CRC16_EN
    localparam bit LAST_ON_PAY = 1'b0;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_STAT = 3'd2,
        ST_PAY  = 3'd3,
        ST_CRC  = 3'd4,
        ST_DONE = 3'd5
    } state_t;
`else
    localparam bit LAST_ON_PAY = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_STAT = 3'd2,
        ST_PAY  = 3'd3,
        ST_DONE = 3'd5
    } state_t;
`endif

    state_t            state_r;
    logic [7:0]        pid_r;
    logic              status_r;
    logic [PAY_W-1:0]  payload_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              beat_s;
`ifdef PD_CRC16_EN
    logic [15:0]       crc_r;
`endif

    // Payload word k lives in the k-th WORD_W slice counted from the MSB end.
    function automatic logic [WORD_W-1:0] pay_word(input logic [PAY_W-1:0] p,
                                                   input logic [CNT_W-1:0] k);
        logic [IDX_W-1:0] top;
        top = IDX_W'((PAYLOAD_WORDS - int'(k)) * WORD_W - 1);
        return p[top -: WORD_W];
    endfunction

`ifdef PD_CRC16_EN
    // One CRC-16/CCITT update over a full word, most significant bit first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [WORD_W-1:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ 16'h1021;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction
`endif

    assign beat_s = tx_valid & tx_ready;

    // Packet FSM: capture on start, advance on beats, outputs registered per next state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= ST_IDLE;
            pid_r     <= 8'd0;
            status_r  <= 1'b0;
            payload_r <= '0;
            cnt_r     <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            tx_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PD_CRC16_EN
            crc_r     <= 16'hFFFF;
`endif
        end else if (abort) begin
            // Abort drops whatever is in flight, including a word accepted this edge.
            state_r  <= ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        pid_r     <= pid;
                        status_r  <= status_empty;
                        payload_r <= payload_in;
                        cnt_r     <= '0;
`ifdef PD_CRC16_EN
                        crc_r     <= 16'hFFFF;
`endif
                        state_r   <= ST_HDR;
                        tx_valid  <= 1'b1;
                        tx_data   <= WORD_W'({SYNC_BYTE, pid});
                        tx_last   <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (beat_s) begin
`ifdef PD_CRC16_EN
                        crc_r   <= crc16_step(crc_r, tx_data);
`endif
                        state_r <= ST_STAT;
                        tx_data <= WORD_W'(status_r);
                    end else begin
                        state_r <= ST_HDR;
                    end
                end
                ST_STAT: begin
                    if (beat_s) begin
`ifdef PD_CRC16_EN
                        crc_r   <= crc16_step(crc_r, tx_data);
`endif
                        state_r <= ST_PAY;
                        tx_data <= pay_word(payload_r, '0);
                        tx_last <= LAST_ON_PAY && (LAST_IDX == '0);
                    end else begin
                        state_r <= ST_STAT;
                    end
                end
                ST_PAY: begin
                    if (beat_s) begin
`ifdef PD_CRC16_EN
                        crc_r <= crc16_step(crc_r, tx_data);
`endif
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_IDX) begin
`ifdef PD_CRC16_EN
                            state_r <= ST_CRC;
                            tx_data <= WORD_W'(crc16_step(crc_r, tx_data));
                            tx_last <= 1'b1;
`else
                            state_r  <= ST_DONE;
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            tx_last  <= 1'b0;
                            done     <= 1'b1;
`endif
                        end else begin
                            tx_data <= pay_word(payload_r, cnt_r + CNT_W'(1));
                            tx_last <= LAST_ON_PAY && ((cnt_r + CNT_W'(1)) == LAST_IDX);
                        end
                    end else begin
                        state_r <= ST_PAY;
                    end
                end
`ifdef PD_CRC16_EN
                ST_CRC: begin
                    if (beat_s) begin
                        state_r  <= ST_DONE;
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        tx_last  <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state_r <= ST_CRC;
                    end
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    tx_valid <= 1'b0;
                    tx_data  <= '0;
                    tx_last  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pd_packet_serializer.sv
// Self-checking bench for pd_packet_serializer: a scoreboard queue holds the
// expected words of each packet; a monitor pops and compares on every beat.
module tb_pd_packet_serializer;

    localparam int W  = 16;
    localparam int PW = 18;
`ifdef PD_CRC16_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif
    localparam int PKT_LEN = PW + 2 + (CRC_ON ? 1 : 0);

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start, abort, status_empty, tx_ready;
    logic [7:0]    pid;
    logic [PW*W-1:0] payload_in;
    logic          tx_valid, tx_last, busy, done;
    logic [W-1:0]  tx_data;

    logic          start_b, abort_b, status_b, ready_b;
    logic [7:0]    pid_b;
    logic [W-1:0]  payload_b;
    logic          valid_b, last_b, busy_b, done_b;
    logic [W-1:0]  data_b;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    exp_t exp_q[$];
    exp_t exp_qb[$];
    logic [W-1:0] pay_words[$];

    logic          prev_stall = 1'b0;
    logic          prev_abort = 1'b0;
    logic [W-1:0]  prev_data = '0;
    logic          prev_last = 1'b0;

    always #5 clk = ~clk;

    pd_packet_serializer #(.WORD_W(W), .PAYLOAD_WORDS(PW), .SYNC_BYTE(8'h80)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .pid(pid),
        .status_empty(status_empty), .payload_in(payload_in), .tx_ready(tx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .busy(busy), .done(done)
    );

    pd_packet_serializer #(.WORD_W(W), .PAYLOAD_WORDS(1), .SYNC_BYTE(8'h80)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_b), .abort(abort_b), .pid(pid_b),
        .status_empty(status_b), .payload_in(payload_b), .tx_ready(ready_b),
        .tx_valid(valid_b), .tx_data(data_b), .tx_last(last_b), .busy(busy_b), .done(done_b)
    );

    // Reference CRC-16/CCITT (0x1021, init 0xFFFF) over one word, MSB first.
    function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [W-1:0] w);
        logic [15:0] c;
        c = c_in;
        for (int b = W - 1; b >= 0; b--) begin
            if (c[15] ^ w[b]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction

    // Push the expected word stream of one packet built from pay_words.
    task automatic push_expected(input logic [7:0] p, input logic s, input bit to_b);
        exp_t e;
        logic [15:0] crc;
        logic [W-1:0] w;
        int n;
        n = pay_words.size();
        crc = 16'hFFFF;
        for (int i = 0; i < n + 2; i++) begin
            if (i == 0)      w = {8'h80, p};
            else if (i == 1) w = {15'd0, s};
            else             w = pay_words[i-2];
            crc = crc_ref(crc, w);
            e.data = w;
            e.last = !CRC_ON && (i == n + 1);
            if (to_b) exp_qb.push_back(e); else exp_q.push_back(e);
        end
        if (CRC_ON) begin
            e.data = crc;
            e.last = 1'b1;
            if (to_b) exp_qb.push_back(e); else exp_q.push_back(e);
        end
    endtask

    task automatic load_payload();
        for (int k = 0; k < PW; k++) payload_in[(PW-k)*W-1 -: W] = pay_words[k];
    endtask

    // Scoreboard monitor for the main instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (n_rst) begin
            if (prev_stall && !prev_abort) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             tx_valid, tx_data, tx_last, prev_data, prev_last);
                end
            end
            if (tx_valid !== 1'b1) begin
                checks++;
                if (tx_data !== '0 || tx_last !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_zero: got d=%h l=%b expected d=0000 l=0", tx_data, tx_last);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1 && abort !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got d=%h expected no word", tx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (tx_data !== e.data || tx_last !== e.last) begin
                        errors++;
                        $display("FAIL beat_word: got d=%h l=%b expected d=%h l=%b",
                                 tx_data, tx_last, e.data, e.last);
                    end
                end
            end
            if (done === 1'b1) done_cnt++;
            prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
            prev_abort = abort;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    task automatic test_reset();
        n_rst = 1'b0;
        start = 1'b0; abort = 1'b0; pid = 8'd0; status_empty = 1'b0; payload_in = '0; tx_ready = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; pid_b = 8'd0; status_b = 1'b0; payload_b = '0; ready_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_valid, tx_data, tx_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_main: got v=%b d=%h l=%b busy=%b done=%b expected all 0",
                     tx_valid, tx_data, tx_last, busy, done);
        end
        checks++;
        if ({valid_b, data_b, last_b, busy_b, done_b} !== '0) begin
            errors++;
            $display("FAIL reset_small: got v=%b d=%h l=%b busy=%b done=%b expected all 0",
                     valid_b, data_b, last_b, busy_b, done_b);
        end
        @(posedge clk); #1 n_rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b v=%b expected 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_basic();
        int n, d0;
        pay_words = {};
        for (int k = 0; k < PW; k++) pay_words.push_back(16'h0100 + W'(k));
        load_payload();
        pid = 8'h2D; status_empty = 1'b1; tx_ready = 1'b1;
        push_expected(8'h2D, 1'b1, 1'b0);
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1;
        checks++;
        if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== 16'h802D) begin
            errors++;
            $display("FAIL start_latency: got v=%b busy=%b d=%h expected 1 1 802d", tx_valid, busy, tx_data);
        end
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || n != PKT_LEN + 1) begin
            errors++;
            $display("FAIL basic_length: got %0d cycles (%0d left) expected %0d cycles",
                     n, exp_q.size(), PKT_LEN + 1);
        end
        exp_q.delete();
        checks++;
        if (done !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: got done=%b v=%b busy=%b expected 1 0 1", done, tx_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL done_once: got done=%b busy=%b pulses=%0d expected 0 0 1", done, busy, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int n, d0;
        logic [0:3] pat;
        pat = 4'b1001;
        pid = 8'h2D; status_empty = 1'b1; tx_ready = 1'b1;
        push_expected(8'h2D, 1'b1, 1'b0);
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1;
        tx_ready = pat[n % 4];
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
            tx_ready = pat[n % 4];
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: got %0d words left expected 0", exp_q.size());
        end
        exp_q.delete();
        tx_ready = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: got pulses=%0d busy=%b expected 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_capture_hold();
        int n, d0;
        pay_words = {};
        for (int k = 0; k < PW; k++) pay_words.push_back(W'($urandom_range(0, 65535)));
        load_payload();
        pid = 8'h3C; status_empty = 1'b0; tx_ready = 1'b1;
        push_expected(8'h3C, 1'b0, 1'b0);
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1;
        while (exp_q.size() != 0 && n < 200) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_hold: got busy=%b expected 1 at cycle %0d", busy, n);
            end
            @(posedge clk); #1;
            n++;
            tx_ready = ($urandom_range(0, 1) == 1);
            if (n == 4) begin
                pid = 8'hFF; status_empty = 1'b1; payload_in = '1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL capture_drain: got %0d words left expected 0", exp_q.size());
        end
        exp_q.delete();
        tx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: got pulses=%0d busy=%b v=%b expected 1 0 0",
                     done_cnt - d0, busy, tx_valid);
        end
    endtask

    task automatic test_abort();
        int n, d0;
        pay_words = {};
        for (int k = 0; k < PW; k++) pay_words.push_back(16'h0100 + W'(k));
        load_payload();
        pid = 8'h2D; status_empty = 1'b1; tx_ready = 1'b1;
        push_expected(8'h2D, 1'b1, 1'b0);
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (tx_data !== 16'h0105 || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_word: got d=%h v=%b expected 0105 1", tx_data, tx_valid);
        end
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != PKT_LEN - 7) begin
            errors++;
            $display("FAIL abort_stop: got v=%b busy=%b left=%0d expected 0 0 %0d",
                     tx_valid, busy, exp_q.size(), PKT_LEN - 7);
        end
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: got pulses=%0d v=%b expected 0 0", done_cnt - d0, tx_valid);
        end
        pay_words = {};
        for (int k = 0; k < PW; k++) pay_words.push_back(16'hA000 + W'(k * 3));
        load_payload();
        pid = 8'h5A; status_empty = 1'b0;
        push_expected(8'h5A, 1'b0, 1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (tx_data !== 16'h805A) begin
            errors++;
            $display("FAIL fresh_header: got %h expected 805a", tx_data);
        end
        n = 1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL fresh_packet: got left=%0d done=%b expected 0 1", exp_q.size(), done);
        end
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_start_abort_same();
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_1: got busy=%b v=%b expected 0 0", busy, tx_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_2: got busy=%b v=%b expected 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_single_word(input logic [7:0] p, input logic s, input logic [W-1:0] w);
        int n;
        exp_t e;
        pay_words = {};
        pay_words.push_back(w);
        pid_b = p; status_b = s; payload_b = w; ready_b = 1'b1;
        push_expected(p, s, 1'b1);
        @(posedge clk); #1 start_b = 1'b1;
        n = 0;
        while (exp_qb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            n++;
            if (valid_b === 1'b1 && ready_b === 1'b1) begin
                e = exp_qb.pop_front();
                checks++;
                if (data_b !== e.data || last_b !== e.last) begin
                    errors++;
                    $display("FAIL small_word: got d=%h l=%b expected d=%h l=%b", data_b, last_b, e.data, e.last);
                end
            end
        end
        checks++;
        if (exp_qb.size() != 0 || n != 3 + (CRC_ON ? 1 : 0)) begin
            errors++;
            $display("FAIL small_length: got %0d cycles (%0d left) expected %0d",
                     n, exp_qb.size(), 3 + (CRC_ON ? 1 : 0));
        end
        exp_qb.delete();
        @(posedge clk); #1;
        checks++;
        if (done_b !== 1'b1 || valid_b !== 1'b0) begin
            errors++;
            $display("FAIL small_done: got done=%b v=%b expected 1 0", done_b, valid_b);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_capture_hold();
        test_abort();
        test_start_abort_same();
        test_single_word(8'h00, 1'b0, 16'h0000);
        test_single_word(8'hA5, 1'b1, 16'hBEEF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
